// File: rtl/anton_neopixel_sequencer.sv
// anton_neopixel_sequencer
// Frame timing sequencer for the NeoPixel stream encoder. It walks every
// pixel of the buffer MSB-first, eight waveform slots per colour bit, then
// holds a latch/reset period before going idle or looping.
//
// Ports:
//   clk, rst_n           pixel clock (8 clocks per bit), async active-low reset
//   reg_ctrl_run         enable; low forces IDLE on the next clock
//   reg_ctrl_32bit       1 = 4 bytes per pixel, 0 = 1 byte per pixel
//   reg_ctrl_loop        restart automatically after each latch period
//   reg_ctrl_init        start request, honoured only in IDLE
//   reg_max              byte index of the last pixel to send
//   state                STATE_TRANSMIT while shifting bits, STATE_RESET otherwise
//   pixel_index          byte index of the first byte of the current pixel
//   pixel_bit_index      colour bit 23..0 of the current pixel
//   bit_pattern_index    waveform slot 0..7 within the current bit
//   busy                 high in TRANSMIT and LATCH
//   frame_done           one-cycle pulse on the final LATCH cycle
//
// BUFFER_END must be at least 4 so that the 32-bit pixel field
// pixel_index[BUFFER_BITS-1:2] exists.
module anton_neopixel_sequencer #(
  parameter int unsigned BUFFER_END   = 255,
  parameter int unsigned RESET_CYCLES = 320,
  localparam int unsigned BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reg_ctrl_run,
  input  logic                   reg_ctrl_32bit,
  input  logic                   reg_ctrl_loop,
  input  logic                   reg_ctrl_init,
  input  logic [BUFFER_BITS-1:0] reg_max,
  output logic                   state,
  output logic [BUFFER_BITS-1:0] pixel_index,
  output logic [4:0]             pixel_bit_index,
  output logic [2:0]             bit_pattern_index,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int unsigned LATCH_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned SLOT_W  = 3;
  localparam int unsigned BIT_W   = 5;

  localparam logic STATE_TRANSMIT = 1'b1;
  localparam logic STATE_RESET    = 1'b0;

  localparam logic [BUFFER_BITS-1:0] BUF_END   = BUFFER_BITS'(BUFFER_END);
  localparam logic [LATCH_W-1:0]     LATCH_TOP = LATCH_W'(RESET_CYCLES - 1);
  localparam logic [BIT_W-1:0]       BIT_TOP   = BIT_W'(23);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TRANSMIT = 2'd1,
    S_LATCH    = 2'd2
  } fsm_e;

  fsm_e                   fsm_q, fsm_d;
  logic [BUFFER_BITS-1:0] pixel_index_q, pixel_index_d;
  logic [BIT_W-1:0]       pixel_bit_index_q, pixel_bit_index_d;
  logic [SLOT_W-1:0]      bit_pattern_index_q, bit_pattern_index_d;
  logic [LATCH_W-1:0]     latch_cnt_q, latch_cnt_d;
  logic [BUFFER_BITS-1:0] max_q, max_d;
  logic                   mode_q, mode_d;
  logic                   state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;

  logic                   last_slot_c;
  logic                   last_bit_c;
  logic                   last_pixel_c;
  logic [BUFFER_BITS-1:0] pixel_step_c;

  // Frame-end detection: stop at the programmed last pixel, or at the end of
  // the physical buffer if the programmed value points past it.
  always_comb begin
    last_slot_c  = (bit_pattern_index_q == SLOT_W'(7));
    last_bit_c   = (pixel_bit_index_q == '0);
    pixel_step_c = mode_q ? BUFFER_BITS'(4) : BUFFER_BITS'(1);
    if (mode_q) begin
      last_pixel_c = (pixel_index_q[BUFFER_BITS-1:2] == max_q[BUFFER_BITS-1:2]) ||
                     (pixel_index_q[BUFFER_BITS-1:2] == BUF_END[BUFFER_BITS-1:2]);
    end else begin
      last_pixel_c = (pixel_index_q == max_q) || (pixel_index_q == BUF_END);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    fsm_d               = fsm_q;
    pixel_index_d       = pixel_index_q;
    pixel_bit_index_d   = pixel_bit_index_q;
    bit_pattern_index_d = bit_pattern_index_q;
    latch_cnt_d         = latch_cnt_q;
    max_d               = max_q;
    mode_d              = mode_q;

    case (fsm_q)
      S_IDLE: begin
        pixel_index_d       = '0;
        pixel_bit_index_d   = BIT_TOP;
        bit_pattern_index_d = '0;
        latch_cnt_d         = '0;
        if (reg_ctrl_init) begin
          fsm_d  = S_TRANSMIT;
          max_d  = reg_max;
          mode_d = reg_ctrl_32bit;
        end
      end

      S_TRANSMIT: begin
        bit_pattern_index_d = bit_pattern_index_q + SLOT_W'(1);
        if (last_slot_c) begin
          if (last_bit_c) begin
            pixel_bit_index_d = BIT_TOP;
            if (last_pixel_c) begin
              fsm_d         = S_LATCH;
              pixel_index_d = '0;
              latch_cnt_d   = LATCH_TOP;
            end else begin
              pixel_index_d = pixel_index_q + pixel_step_c;
            end
          end else begin
            pixel_bit_index_d = pixel_bit_index_q - BIT_W'(1);
          end
        end
      end

      S_LATCH: begin
        if (latch_cnt_q == '0) begin
          if (reg_ctrl_loop) begin
            fsm_d  = S_TRANSMIT;
            max_d  = reg_max;
            mode_d = reg_ctrl_32bit;
          end else begin
            fsm_d = S_IDLE;
          end
        end else begin
          latch_cnt_d = latch_cnt_q - LATCH_W'(1);
        end
      end

      default: begin
        fsm_d = S_IDLE;
      end
    endcase

    // Dropping run aborts from any state; the encoder already idles the line.
    if (!reg_ctrl_run) begin
      fsm_d               = S_IDLE;
      pixel_index_d       = '0;
      pixel_bit_index_d   = BIT_TOP;
      bit_pattern_index_d = '0;
      latch_cnt_d         = '0;
    end

    state_d      = (fsm_d == S_TRANSMIT) ? STATE_TRANSMIT : STATE_RESET;
    busy_d       = (fsm_d != S_IDLE);
    frame_done_d = (fsm_d == S_LATCH) && (latch_cnt_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q               <= S_IDLE;
      pixel_index_q       <= '0;
      pixel_bit_index_q   <= BIT_TOP;
      bit_pattern_index_q <= '0;
      latch_cnt_q         <= '0;
      max_q               <= '0;
      mode_q              <= 1'b0;
      state_q             <= STATE_RESET;
      busy_q              <= 1'b0;
      frame_done_q        <= 1'b0;
    end else begin
      fsm_q               <= fsm_d;
      pixel_index_q       <= pixel_index_d;
      pixel_bit_index_q   <= pixel_bit_index_d;
      bit_pattern_index_q <= bit_pattern_index_d;
      latch_cnt_q         <= latch_cnt_d;
      max_q               <= max_d;
      mode_q              <= mode_d;
      state_q             <= state_d;
      busy_q              <= busy_d;
      frame_done_q        <= frame_done_d;
    end
  end

  assign state             = state_q;
  assign pixel_index       = pixel_index_q;
  assign pixel_bit_index   = pixel_bit_index_q;
  assign bit_pattern_index = bit_pattern_index_q;
  assign busy              = busy_q;
  assign frame_done        = frame_done_q;

endmodule

// File: doc/anton_neopixel_sequencer.md
# anton_neopixel_sequencer

Timing sequencer for the NeoPixel output stream. It owns the frame state machine and generates the `state`, `pixel_index`, `pixel_bit_index` and `bit_pattern_index` values that select the current byte(s), bit and waveform slot in the combinational stream encoder. It sits between the register/bus block (`reg_ctrl_*`, `reg_max`) and the stream encoder, and runs on the 6.4 MHz pixel clock (8 clocks per NeoPixel bit).

## Interface
- `BUFFER_END`, `` `BUFFER_END_DEFAULT ``: index of the last byte in the pixel buffer.
- `BUFFER_BITS`, `` `CLOG2(BUFFER_END+1) ``: localparam; width of pixel indices.
- `RESET_CYCLES`, 320: length of the latch/reset low period in clocks (50 µs at 6.4 MHz). Must be ≥ 2.

- `clk`  in  1  pixel clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reg_ctrl_run`  in  1  enable. Low forces IDLE.
- `reg_ctrl_32bit`  in  1  1 = 4 bytes per pixel (byte 3 unused); 0 = 1 byte per pixel.
- `reg_ctrl_loop`  in  1  1 = restart automatically after each latch period.
- `reg_ctrl_init`  in  1  one-cycle start request; used only in IDLE.
- `reg_max`  in  BUFFER_BITS  byte index of the last pixel to send.
- `state`  out  1  `` `ENUM_STATE_TRANSMIT `` in TRANSMIT; `` `ENUM_STATE_RESET `` otherwise.
- `pixel_index`  out  BUFFER_BITS  byte index of the first byte of the current pixel.
- `pixel_bit_index`  out  5  bit within the 24-bit colour. Counts 23 down to 0 (MSB first).
- `bit_pattern_index`  out  3  waveform slot 0–7 within the current bit.
- `busy`  out  1  high in TRANSMIT and LATCH.
- `frame_done`  out  1  one-cycle pulse on the final LATCH cycle.

## Operation
- FSM states: IDLE, TRANSMIT, LATCH. Encoded internally; only `state`/`busy` are exported.
- **IDLE**
  - Outputs: `pixel_index`=0, `pixel_bit_index`=23, `bit_pattern_index`=0, `busy`=0.
  - `reg_ctrl_run && reg_ctrl_init` → TRANSMIT.
  - On that transition, `reg_max` is captured into `max_q` and `reg_ctrl_32bit` into `mode_q`. Both are held for the whole frame; mid-frame register writes have no effect until the next frame.
- **TRANSMIT**, per clock:
  - `bit_pattern_index` increments, wrapping 7→0.
  - On the 7→0 wrap, `pixel_bit_index` decrements.
  - On the wrap that would take `pixel_bit_index` below 0, it reloads 23 and the pixel advances.
- **Pixel advance**
  - `mode_q`=0: `pixel_index` += 1.
  - `mode_q`=1: `pixel_index` += 4. `pixel_index[1:0]` is always 00 in 32-bit mode.
  - Addition is modulo 2^BUFFER_BITS.
- **Last-pixel test**
  - `mode_q`=0: `pixel_index == max_q`.
  - `mode_q`=1: `pixel_index[BUFFER_BITS-1:2] == max_q[BUFFER_BITS-1:2]`.
  - If `max_q` exceeds BUFFER_END, the frame also ends at the pixel whose index is BUFFER_END (32-bit: the pixel containing byte BUFFER_END). The index never wraps past the buffer.
- Completing bit 0, slot 7 of the last pixel → LATCH.
  - `pixel_index` → 0, `pixel_bit_index` → 23, `bit_pattern_index` → 0.
  - The latch counter loads `RESET_CYCLES-1`.
- **LATCH**
  - Counter decrements each clock. At 0: `frame_done`=1 for that cycle.
  - Next state: TRANSMIT if `reg_ctrl_loop && reg_ctrl_run`, re-capturing `max_q`/`mode_q`; otherwise IDLE.
- **`reg_ctrl_run` low in any state** → IDLE next clock.
  - Counters are cleared; no `frame_done`.
  - The encoder holds the line low by itself because run is low.
- `reg_ctrl_init` in TRANSMIT or LATCH is ignored.

## Timing
- Reset values: FSM=IDLE, `state`=`` `ENUM_STATE_RESET ``, `pixel_index`=0, `pixel_bit_index`=23, `bit_pattern_index`=0, `busy`=0, `frame_done`=0, `max_q`=0, `mode_q`=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Start latency: init sampled high at edge k → `state`=TRANSMIT with slot 0 of bit 23 of pixel 0 in cycle k+1.
- Frame length: TRANSMIT lasts P×192 clocks.
  - P = number of pixels: `max_q+1` (8-bit mode) or `max_q[..:2]+1` (32-bit mode).
  - LATCH lasts exactly `RESET_CYCLES` clocks.
  - Loop mode period: P×192 + RESET_CYCLES, with no gap cycles.
- `reg_max`=0 is a legal one-pixel frame of 192 TRANSMIT cycles.
- Asserting `rst_n` mid-frame returns all outputs to reset values immediately (asynchronously).

## Test plan
- **8-bit frame:** `reg_max`=2, mode 0, loop 0, init pulse.
  - `state`=1 for exactly 576 clocks.
  - `pixel_index` sequence 0,1,2.
  - `pixel_bit_index` 23→0 in each pixel.
  - Then 320 LATCH clocks, `frame_done` on the last one, then IDLE.
- **32-bit frame:** `reg_max`=11, mode 1.
  - `pixel_index` sequence 0,4,8; 576 TRANSMIT clocks.
  - Repeat with `reg_max`=9: same result (low bits ignored).
- **Loop:** loop=1, `reg_max`=0.
  - Period 192+320=512 clocks.
  - `frame_done` every 512 clocks.
  - Changing `reg_max` to 1 mid-frame takes effect on the following frame only.
- **Abort:** `reg_ctrl_run` dropped at cycle 100 of TRANSMIT.
  - IDLE next clock, all counters at idle values, no `frame_done`.
  - A later init starts from pixel 0, bit 23.
- **Clamp:** `reg_max`=2^BUFFER_BITS−1 with BUFFER_END=7, mode 0.
  - Frame ends after pixel 7 (1536 clocks).
  - `pixel_index` never exceeds 7.
- **Reset:** `rst_n` asserted during LATCH and again during TRANSMIT.
  - All outputs at reset values the same cycle.
  - Init is ignored while `rst_n` is low.
